// File: rtl/bit_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu_seq
// Purpose  : Drives a one-bit ALU slice LSB-first over WIDTH cycles and
//            reassembles the WIDTH-bit result and final carry.
// Options  : ALU_ZERO_FLAG_EN adds a registered 'zero' output.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_s,
    input  logic             cin_init,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_s,
    input  logic             alu_out,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef ALU_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [2:0]       s_reg;
    logic             carry;
`ifdef ALU_ZERO_FLAG_EN
    logic             any_one;
`endif

    logic             in_shift;
    logic [WIDTH-1:0] acc_next;

    assign in_shift = (state == SHIFT);
    // Slice inputs are forced low outside SHIFT so the slice sees quiet inputs.
    assign alu_a    = in_shift & a_sh[0];
    assign alu_b    = in_shift & b_sh[0];
    assign alu_cin  = in_shift & carry;
    assign alu_s    = in_shift ? s_reg : 3'b000;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign acc_next = {alu_out, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            s_reg  <= 3'b000;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            any_one <= 1'b0;
            zero    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b;
                        s_reg <= op_s;
                        carry <= cin_init;
                        cnt   <= '0;
`ifdef ALU_ZERO_FLAG_EN
                        any_one <= 1'b0;
`endif
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= acc_next;
                    carry <= alu_cout;
`ifdef ALU_ZERO_FLAG_EN
                    any_one <= any_one | alu_out;
`endif
                    if (cnt == LAST_BIT) begin
                        // The last slice bit lands straight in result.
                        result <= acc_next;
                        cout   <= alu_cout;
`ifdef ALU_ZERO_FLAG_EN
                        zero   <= ~(any_one | alu_out);
`endif
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bit_serial_alu_seq.md
Name: bit_serial_alu_seq

Overview:
- Bit-serial sequencer that sits directly upstream and downstream of the one-bit ALU slice (ports a, b, cin, s[2:0] in; aluOut, aluCout out).
- Accepts a WIDTH-bit operand pair and a 3-bit select. Feeds the slice one bit per clock, LSB first, and chains the slice carry through a register.
- Reassembles the slice outputs into a WIDTH-bit result plus carry-out.
- Forms the serial datapath of the 8-bit ALU using a single slice instance.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous and active-low (single clock domain, sync active-low reset).
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  WIDTH  operand A, captured on an accepted start.
- op_b  input  WIDTH  operand B, captured on an accepted start.
- op_s  input  3  slice select, captured on an accepted start.
- cin_init  input  1  carry into bit 0, captured on an accepted start (1 for subtract-style ops).
- alu_a  output  1  to slice a.
- alu_b  output  1  to slice b.
- alu_cin  output  1  to slice cin.
- alu_s  output  3  to slice s.
- alu_out  input  1  from slice aluOut.
- alu_cout  input  1  from slice aluCout.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse: result/cout valid.
- result  output  WIDTH  assembled result; held until the next completion.
- cout  output  1  final slice carry; held until the next completion.

Behaviour:
- States: IDLE, SHIFT, DONE. Bit counter is clog2(WIDTH) bits wide.
- Reset (rst_n=0 at an edge): state=IDLE, counter=0, operand/result/carry registers=0. Outputs busy=0, done=0, result=0, cout=0, alu_*=0.
- Reset mid-operation aborts the operation: no done, result/cout return to 0.
- IDLE:
  - start=1 at an edge: load a_sh=op_a, b_sh=op_b, s_reg=op_s, carry=cin_init, counter=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, combinational slice drive: alu_a=a_sh[0], alu_b=b_sh[0], alu_cin=carry, alu_s=s_reg.
- SHIFT, each edge:
  - a_sh and b_sh shift right.
  - Accumulator shifts right with alu_out inserted at the MSB.
  - carry<=alu_cout; counter increments.
- SHIFT exit: at the edge where counter==WIDTH-1:
  - result<=final accumulator value, including this cycle's alu_out.
  - cout<=alu_cout.
  - Go to DONE.
- SHIFT lasts exactly WIDTH cycles; the slice sees bit i in SHIFT cycle i.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge.
- Latency: start sampled at edge T gives done high during the cycle after edge T+WIDTH.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored with no side effects. The captured operands are unaffected by op_a/op_b/op_s changes.
- Outside SHIFT: alu_a=0, alu_b=0, alu_cin=0, alu_s=0.
- Carry is always chained; select ops with a don't-care carry are unaffected.
- No wrap-around: the counter never advances past WIDTH-1; it resets to 0 on the next accepted start.
- result/cout change only at SHIFT exit or reset.

Optional Feature:
- Macro ALU_ZERO_FLAG_EN.
- Defined: adds output zero (1 bit).
  - A sticky OR of all alu_out bits is accumulated during SHIFT and cleared on an accepted start.
  - zero is registered at SHIFT exit as (result==0), aligned with done and held like result.
  - Reset value of zero is 0.
- Undefined: port and logic are absent; the interface is otherwise identical.

Test Plan:
- The bench wires a behavioural slice model: s=000 full-add (sum=a^b^cin, cout=majority); s=001 AND (cout=0); s=010 OR (cout=0); s=011 XOR (cout=0).
- ADD, WIDTH=8: op_a=8'h3C, op_b=8'h0F, cin_init=0 → done 9 cycles after start edge, result=8'h4B, cout=0. Slice sees alu_a=0,0,1,1,1,1,0,0 over SHIFT cycles 0..7.
- ADD with carry out: op_a=8'hFF, op_b=8'h01, cin_init=0 → result=8'h00, cout=1; zero=1 when ALU_ZERO_FLAG_EN is defined.
- Logic op: s=001, op_a=8'hF0, op_b=8'hAA → result=8'hA0, cout=0.
- start pulsed again in SHIFT cycle 3 with op_a=8'h00 → ignored. The original result appears on time; exactly one done pulse; busy stays high through DONE.
- rst_n=0 in SHIFT cycle 4 → next cycle busy=0, result=0, no done pulse. A fresh start then completes normally with the correct result.
